// File: rtl/snn_mem_arbiter_if.sv
// Host, core and SRAM-macro signal bundle for snn_mem_arbiter.
// slave = arbiter view; master = requesters plus macro (bench or parent).
interface snn_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) ();
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        input  core_req, core_addr,
        output core_gnt, core_rvalid, core_rdata,
        output sram_csb, sram_web, sram_addr, sram_din,
        input  sram_dout
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        output core_req, core_addr,
        input  core_gnt, core_rvalid, core_rdata,
        input  sram_csb, sram_web, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/snn_mem_arbiter.sv
// Host/core arbiter for one 1rw SRAM macro: registered pins, tagged 2-cycle read return.
// Optional host starvation guard enabled by defining SNN_ARB_STARVE_GUARD_EN.
module snn_mem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic              clk,
    input logic              rst_n,
    input logic              busy_i,
    snn_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHost, StCore} owner_e;

    owner_e            state_q, state_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    // Tag stage 0 is the read flag; its owner is state_q (owner of the pins).
    logic              rd0_q, rd0_d;
    logic              rd1_q, rd1_d;
    logic              own1_core_q, own1_core_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;

    logic host_win;
    logic core_win;
    logic host_starved;

`ifdef SNN_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    assign host_starved = (starve_cnt_q >= CntW'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.host_req || host_win) begin
            starve_cnt_d = '0;
        end else if (!host_starved) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;

    assign host_starved        = 1'b0;
    assign unused_starve_limit = ^STARVE_LIMIT;
`endif

    always_comb begin
        host_win = bus.host_req && (!bus.core_req || !busy_i || host_starved);
        core_win = bus.core_req && !host_win;
    end

    always_comb begin
        state_d      = StIdle;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        addr_d       = addr_q;
        din_d        = din_q;
        rd0_d        = 1'b0;
        rd1_d        = rd0_q;
        own1_core_d  = (state_q == StCore);
        host_rdata_d = host_rdata_q;
        core_rdata_d = core_rdata_q;

        if (host_win) begin
            state_d = StHost;
            csb_d   = 1'b0;
            web_d   = !bus.host_we;
            addr_d  = bus.host_addr;
            rd0_d   = !bus.host_we;
            if (bus.host_we) begin
                din_d = bus.host_wdata;
            end
        end else if (core_win) begin
            state_d = StCore;
            csb_d   = 1'b0;
            addr_d  = bus.core_addr;
            rd0_d   = 1'b1;
        end

        // Macro dout is valid while the read command sits on the pins.
        if (rd0_q && (state_q == StHost)) begin
            host_rdata_d = bus.sram_dout;
        end
        if (rd0_q && (state_q == StCore)) begin
            core_rdata_d = bus.sram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            addr_q       <= '0;
            din_q        <= '0;
            rd0_q        <= 1'b0;
            rd1_q        <= 1'b0;
            own1_core_q  <= 1'b0;
            host_rdata_q <= '0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            own1_core_q  <= own1_core_d;
            host_rdata_q <= host_rdata_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    always_comb begin
        bus.host_gnt    = host_win;
        bus.core_gnt    = core_win;
        bus.host_rvalid = rd1_q && !own1_core_q;
        bus.core_rvalid = rd1_q && own1_core_q;
        bus.host_rdata  = host_rdata_q;
        bus.core_rdata  = core_rdata_q;
        bus.sram_csb    = csb_q;
        bus.sram_web    = web_q;
        bus.sram_addr   = addr_q;
        bus.sram_din    = din_q;
    end

endmodule

// File: tb/tb_snn_mem_arbiter.sv
// Scoreboard bench for snn_mem_arbiter: grants push expected read data, a monitor pops on rvalid.
// Define SNN_ARB_STARVE_GUARD_EN to check the guarded build.
module tb_snn_mem_arbiter;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   core_rx;
    int   rx_base;
    int   hg;

    logic [7:0] mem     [1024];
    logic [7:0] exp_mem [1024];
    exp_t       host_q  [$];
    exp_t       core_q  [$];

    snn_mem_arbiter_if #(.ADDR_W(10), .DATA_W(8)) ifc ();

    snn_mem_arbiter #(
        .ADDR_W      (10),
        .DATA_W      (8),
        .STARVE_LIMIT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .busy_i(busy),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // SRAM macro model: write on clock edge, read data follows the registered pins.
    always @(posedge clk) begin
        if (!ifc.sram_csb && !ifc.sram_web) mem[ifc.sram_addr] = ifc.sram_din;
    end
    assign ifc.sram_dout = mem[ifc.sram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issuer side of the scoreboard: every read grant queues its expected data and due cycle.
    always @(negedge clk) begin
        if (ifc.host_gnt) begin
            if (ifc.host_we) exp_mem[ifc.host_addr] = ifc.host_wdata;
            else host_q.push_back('{data: exp_mem[ifc.host_addr], cyc: cyc + 2});
        end
        if (ifc.core_gnt) core_q.push_back('{data: exp_mem[ifc.core_addr], cyc: cyc + 2});
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ifc.host_rvalid) begin
            if (host_q.size() == 0) begin
                check("host_rvalid_spurious", 32'(host_q.size()), 32'd1);
            end else begin
                e = host_q.pop_front();
                check("host_rdata", 32'(ifc.host_rdata), 32'(e.data));
                check("host_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ifc.core_rvalid) begin
            core_rx++;
            if (core_q.size() == 0) begin
                check("core_rvalid_spurious", 32'(core_q.size()), 32'd1);
            end else begin
                e = core_q.pop_front();
                check("core_rdata", 32'(ifc.core_rdata), 32'(e.data));
                check("core_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csb_web"}, 32'({ifc.sram_csb, ifc.sram_web}), 32'b11);
        check({tag, "_sram_addr"}, 32'(ifc.sram_addr), 32'd0);
        check({tag, "_sram_din"}, 32'(ifc.sram_din), 32'd0);
        check({tag, "_rvalids"}, 32'({ifc.host_rvalid, ifc.core_rvalid}), 32'b00);
        check({tag, "_host_rdata"}, 32'(ifc.host_rdata), 32'd0);
        check({tag, "_core_rdata"}, 32'(ifc.core_rdata), 32'd0);
    endtask

    task automatic host_op(input logic we, input logic [9:0] a, input logic [7:0] d);
        int w;
        w              = 0;
        ifc.host_req   = 1'b1;
        ifc.host_we    = we;
        ifc.host_addr  = a;
        ifc.host_wdata = d;
        @(negedge clk);
        while (!ifc.host_gnt && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("host_gnt_wait", 32'(ifc.host_gnt), 32'd1);
        @(posedge clk);
        #1;
        ifc.host_req = 1'b0;
        ifc.host_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        core_rx        = 0;
        rst_n          = 1'b1;
        busy           = 1'b0;
        ifc.host_req   = 1'b0;
        ifc.host_we    = 1'b0;
        ifc.host_addr  = '0;
        ifc.host_wdata = '0;
        ifc.core_req   = 1'b0;
        ifc.core_addr  = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i);
            exp_mem[i] = 8'(i);
        end

        // Reset values
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("reset_gnts", 32'({ifc.host_gnt, ifc.core_gnt}), 32'b00);
        @(posedge clk);
        #1;

        // Idle
        repeat (5) begin
            @(negedge clk);
            check("idle_csb_gnt_rvalid",
                  32'({ifc.sram_csb, ifc.host_gnt, ifc.core_gnt, ifc.host_rvalid,
                       ifc.core_rvalid}), 32'b10000);
        end
        @(posedge clk);
        #1;

        // Host write then read
        host_op(1'b1, 10'h012, 8'hA5);
        @(negedge clk);
        check("write_pins_csb_web", 32'({ifc.sram_csb, ifc.sram_web}), 32'b00);
        check("write_pins_addr", 32'(ifc.sram_addr), 32'h012);
        check("write_pins_din", 32'(ifc.sram_din), 32'hA5);
        @(posedge clk);
        #1;
        check("write_one_cycle", 32'({ifc.sram_csb, ifc.sram_web}), 32'b11);
        host_op(1'b0, 10'h012, 8'h00);
        @(posedge clk);
        #1;
        check("host_rvalid_t2", 32'(ifc.host_rvalid), 32'd1);
        check("host_rdata_a5", 32'(ifc.host_rdata), 32'hA5);
        @(posedge clk);
        #1;
        check("host_rvalid_pulse", 32'(ifc.host_rvalid), 32'd0);
        check("host_rdata_hold", 32'(ifc.host_rdata), 32'hA5);

        // Back-to-back write/read at the top address
        host_op(1'b1, 10'h3FF, 8'h3C);
        host_op(1'b0, 10'h3FF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("host_rdata_3c", 32'(ifc.host_rdata), 32'h3C);

        // Contention
        busy          = 1'b1;
        ifc.host_req  = 1'b1;
        ifc.host_we   = 1'b0;
        ifc.host_addr = 10'h020;
        ifc.core_req  = 1'b1;
        ifc.core_addr = 10'h005;
        repeat (4) begin
            @(negedge clk);
            check("contention_busy_core", 32'({ifc.host_gnt, ifc.core_gnt}), 32'b01);
        end
        @(posedge clk);
        #1 busy = 1'b0;
        @(negedge clk);
        check("contention_idle_host", 32'({ifc.host_gnt, ifc.core_gnt}), 32'b10);
        @(posedge clk);
        #1 ifc.host_req = 1'b0;
        @(negedge clk);
        check("contention_core_after", 32'({ifc.host_gnt, ifc.core_gnt}), 32'b01);
        @(posedge clk);
        #1 ifc.core_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Core streaming 0..9
        rx_base = core_rx;
        for (int i = 0; i < 10; i++) begin
            ifc.core_req  = 1'b1;
            ifc.core_addr = 10'(i);
            @(negedge clk);
            check("stream_gnt", 32'(ifc.core_gnt), 32'd1);
            @(posedge clk);
            #1;
        end
        ifc.core_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stream_pulses", 32'(core_rx - rx_base), 32'd10);
        check("stream_last_data", 32'(ifc.core_rdata), 32'd9);

        // Starvation
        hg            = -1;
        busy          = 1'b1;
        ifc.host_req  = 1'b1;
        ifc.host_we   = 1'b0;
        ifc.host_addr = 10'h030;
        ifc.core_req  = 1'b1;
        ifc.core_addr = 10'h040;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.host_gnt) begin
                hg = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (hg >= 0) begin
            @(posedge clk);
            #1 ifc.host_req = 1'b0;
            @(negedge clk);
            check("starve_core_resumes", 32'({ifc.host_gnt, ifc.core_gnt}), 32'b01);
        end
`ifdef SNN_ARB_STARVE_GUARD_EN
        check("starve_host_gnt_index", 32'(hg), 32'd8);
`else
        check("starve_host_never", 32'(hg), 32'hFFFF_FFFF);
`endif
        @(posedge clk);
        #1;
        ifc.host_req = 1'b0;
        ifc.core_req = 1'b0;
        busy         = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-flight
        ifc.core_req  = 1'b1;
        ifc.core_addr = 10'h007;
        @(negedge clk);
        check("midflight_gnt", 32'(ifc.core_gnt), 32'd1);
        @(posedge clk);
        #1;
        ifc.core_req = 1'b0;
        rst_n        = 1'b0;
        core_q.delete();
        #1 check_reset_outputs("midflight");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midflight_no_rvalid", 32'(ifc.core_rvalid), 32'd0);
        end

        check("host_queue_drained", 32'(host_q.size()), 32'd0);
        check("core_queue_drained", 32'(core_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
